// File: rtl/dmac_pkg.sv
// Shared types for the DMA read-burst scheduler: channel index, AXI length,
// scheduler state and the owner-tracking FIFO entry.
package dmac_pkg;
  localparam int DEF_CHANNEL_COUNT = 8;
  localparam int CH_WD = $clog2(DEF_CHANNEL_COUNT);

  typedef logic [CH_WD-1:0] ch_idx_t;
  typedef logic [7:0]       axi_len_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  typedef struct packed {
    ch_idx_t  ch;
    axi_len_t len;
  } owner_entry_t;
endpackage

// File: rtl/dmac_rd_burst_sched_if.sv
// Channel request and AXI AR bus between the scheduler and its environment.
interface dmac_rd_burst_sched_if #(
  parameter int ADDR_WD       = 32,
  parameter int CHANNEL_COUNT = 8
);
  localparam int CH_WD = $clog2(CHANNEL_COUNT);

  // Valid/ready: a transfer happens on a rising clk edge where both are 1; once
  // raised, valid and its payload hold until that edge. ch_req_ready is a
  // one-hot, same-cycle accept and may depend combinationally on ch_req_valid.
  logic [CHANNEL_COUNT-1:0]         ch_req_valid;
  logic [CHANNEL_COUNT-1:0]         ch_req_ready;
  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_req_addr;
  logic [CHANNEL_COUNT*8-1:0]       ch_req_len;
  logic                             ar_valid;
  logic                             ar_ready;
  logic [ADDR_WD-1:0]               ar_addr;
  logic [7:0]                       ar_len;
  logic [CH_WD-1:0]                 ar_id;

  modport master (
    input  ch_req_valid, ch_req_addr, ch_req_len, ar_ready,
    output ch_req_ready, ar_valid, ar_addr, ar_len, ar_id
  );

  modport slave (
    output ch_req_valid, ch_req_addr, ch_req_len, ar_ready,
    input  ch_req_ready, ar_valid, ar_addr, ar_len, ar_id
  );
endinterface

// File: rtl/dmac_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, with wrap.
module dmac_rr_arbiter #(
  parameter int N      = 8,
  parameter int IDX_WD = $clog2(N)
) (
  input  logic [N-1:0]      req,
  input  logic [IDX_WD-1:0] ptr,
  output logic [N-1:0]      grant,
  output logic [IDX_WD-1:0] idx,
  output logic              any
);
  always_comb begin
    int s;
    logic [IDX_WD-1:0] c;
    s     = 0;
    c     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      c = IDX_WD'(s);
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end
endmodule

// File: rtl/dmac_rd_burst_sched.sv
// Read-burst scheduler: round-robin channel arbitration gated by buffer credit
// and an outstanding-burst limit, one AR at a time, plus buffer-write ownership.
module dmac_rd_burst_sched
  import dmac_pkg::*;
#(
  parameter int ADDR_WD         = 32,
  parameter int CHANNEL_COUNT   = DEF_CHANNEL_COUNT,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  dmac_rd_burst_sched_if.master           bus,
  input  logic [$clog2(MAX_BURST_LEN):0]  buf_fill_level,
  input  logic                            buf_wr_beat,
  input  logic                            buf_wr_last,
  output logic                            owner_valid,
  output ch_idx_t                         owner_ch,
  output logic                            err_len,
  output logic                            idle,
  output sched_state_e                    state
);
  localparam int FILL_WD = $clog2(MAX_BURST_LEN) + 1;
  localparam int FREE_WD = FILL_WD + 1;
  localparam int PTR_WD  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_WD  = $clog2(MAX_OUTSTANDING + 1);

  logic [FILL_WD-1:0]       reserved;
  logic [FREE_WD-1:0]       free;
  logic [FREE_WD-1:0]       res_sum;
  logic [FREE_WD-1:0]       res_next;
  ch_idx_t                  rr_ptr;
  owner_entry_t             fifo_q [MAX_OUTSTANDING];
  owner_entry_t             head;
  logic [PTR_WD-1:0]        wr_ptr;
  logic [PTR_WD-1:0]        rd_ptr;
  logic [CNT_WD-1:0]        count;
  axi_len_t                 beat_cnt;
  logic [CHANNEL_COUNT-1:0] eligible;
  logic [CHANNEL_COUNT-1:0] bad_len;
  logic [CHANNEL_COUNT-1:0] grant;
  ch_idx_t                  grant_idx;
  logic                     grant_any;
  logic [ADDR_WD-1:0]       sel_addr;
  axi_len_t                 sel_len;
  logic                     ar_hs;
  logic                     beat_ok;
  logic                     pop;
  logic                     beat_err;

  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  dmac_rr_arbiter #(.N(CHANNEL_COUNT), .IDX_WD($bits(ch_idx_t))) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign head        = fifo_q[rd_ptr];
  assign owner_valid = (count != '0);
  assign owner_ch    = head.ch;
  assign idle        = (state == IDLE) && (count == '0);
  assign ar_hs       = bus.ar_valid && bus.ar_ready;
  assign beat_ok     = buf_wr_beat && owner_valid;
  assign pop         = beat_ok && buf_wr_last;
  // Gated by rst so nothing is accepted while the tracking state is held in reset.
  assign bus.ch_req_ready = (rst && state == IDLE) ? grant : '0;

  always_comb begin
    free     = FREE_WD'(MAX_BURST_LEN) - FREE_WD'(buf_fill_level) - FREE_WD'(reserved);
    bad_len  = '0;
    eligible = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      bad_len[c]  = bus.ch_req_valid[c] &&
                    (9'(bus.ch_req_len[c*8 +: 8]) >= 9'(MAX_BURST_LEN));
      eligible[c] = bus.ch_req_valid[c] && !bad_len[c] &&
                    (9'(bus.ch_req_len[c*8 +: 8]) + 9'd1 <= 9'(free)) &&
                    (count < CNT_WD'(MAX_OUTSTANDING));
      if (ch_idx_t'(c) == grant_idx) begin
        sel_addr = bus.ch_req_addr[c*ADDR_WD +: ADDR_WD];
        sel_len  = bus.ch_req_len[c*8 +: 8];
      end
    end

    // A beat with nothing outstanding is dropped, so reserved bottoms out at 0.
    res_sum  = FREE_WD'(reserved) +
               (ar_hs ? FREE_WD'(bus.ar_len) + FREE_WD'(1) : '0);
    res_next = (beat_ok && res_sum != '0) ? res_sum - 1'b1 : res_sum;

    beat_err = 1'b0;
    if (buf_wr_beat) begin
      if (!owner_valid)     beat_err = 1'b1;
      else if (buf_wr_last) beat_err = (beat_cnt != head.len);
      else                  beat_err = (beat_cnt >= head.len);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bus.ar_valid <= 1'b0;
      bus.ar_addr  <= '0;
      bus.ar_len   <= '0;
      bus.ar_id    <= '0;
      rr_ptr       <= '0;
      reserved     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      beat_cnt     <= '0;
      err_len      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      err_len  <= beat_err || (|bad_len);
      reserved <= FILL_WD'(res_next);

      case (state)
        IDLE: if (grant_any) begin
          bus.ar_valid <= 1'b1;
          bus.ar_addr  <= sel_addr;
          bus.ar_len   <= sel_len;
          bus.ar_id    <= grant_idx;
          state        <= ISSUE;
        end
        ISSUE: if (bus.ar_ready) begin
          bus.ar_valid <= 1'b0;
          rr_ptr       <= (bus.ar_id == ch_idx_t'(CHANNEL_COUNT - 1)) ? '0 : bus.ar_id + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (ar_hs) begin
        fifo_q[wr_ptr] <= '{ch: bus.ar_id, len: bus.ar_len};
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({ar_hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // beat_cnt saturates at head.len so an overlong burst keeps flagging errors.
      if (beat_ok) begin
        if (buf_wr_last)               beat_cnt <= '0;
        else if (beat_cnt < head.len)  beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule
